hcp_sampler_param: RTL and testbench

Parametrised challenge-parsing sampler for the Picnic-on-SM4 signer. It takes a hash digest, slices it MSB-first into FIELD_W-bit chunks, and rejection-samples NUM_OUT values below BOUND. When the digest runs out before all slots are filled, it re-hashes the current digest through an external hash core over a req/valid handshake. It sits between the challenge hash and the opening-selection logic, and replaces the fixed 4×5-bit parser with a generic, bounded-retry engine.

---
 rtl/hcp_sampler_param.sv | 204 ++++++++++++++++++++
 tb/tb_hcp_sampler_param.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hcp_sampler_param.sv
// hcp_sampler_param: parametrised challenge-parsing sampler.
//
// Slices a digest MSB-first into FIELD_W-bit chunks and keeps each chunk whose
// value is below BOUND until NUM_OUT values are collected. When a digest runs
// out of whole chunks, the current digest is sent out for re-hashing over a
// req/valid handshake. After MAX_REHASH re-hashes the run aborts with err.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, seed        one-cycle run request (IDLE only) and initial digest
//   hash_req, hash_in  re-hash request and the message to hash
//   hash_valid, hash_out  hash core result strobe and new digest
//   busy               high while scanning or re-hashing
//   done, err          one-cycle completion pulse; err=1 means retries ran out
//   out_vec            collected values, slot 0 in the MSBs
//   rehash_cnt         re-hashes used by the last/current run

// One result slot. Captures the current chunk when the scan accepts it and
// this slot is the one being filled. nxt is the value it will hold after the
// edge, so the parent can register out_vec in the same cycle the last slot fills.
module hcp_sampler_slot #(
    parameter int FIELD_W = 5,
    parameter int IW      = 3,
    parameter int IDX     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               acc,
    input  logic [IW-1:0]      idx,
    input  logic [FIELD_W-1:0] chunk,
    output logic [FIELD_W-1:0] nxt
);
    logic [FIELD_W-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clr)
            slot_d = '0;
        else if (acc && idx == IW'(IDX))
            slot_d = chunk;
    end

    always_ff @(posedge clk) begin
        if (reset) slot_q <= '0;
        else       slot_q <= slot_d;
    end

    assign nxt = slot_d;
endmodule

module hcp_sampler_param #(
    parameter int HASH_W     = 256,
    parameter int FIELD_W    = 5,
    parameter int BOUND      = 16,
    parameter int NUM_OUT    = 4,
    parameter int MAX_REHASH = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [HASH_W-1:0]          seed,
    output logic                       hash_req,
    output logic [HASH_W-1:0]          hash_in,
    input  logic                       hash_valid,
    input  logic [HASH_W-1:0]          hash_out,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [NUM_OUT*FIELD_W-1:0] out_vec,
    output logic [7:0]                 rehash_cnt
);
    localparam int CHUNKS = HASH_W / FIELD_W;
    localparam int CW     = $clog2(CHUNKS + 1);
    localparam int IW     = $clog2(NUM_OUT + 1);
    // One extra bit so BOUND == 2^FIELD_W (accept everything) is representable.
    localparam logic [FIELD_W:0] BOUND_L = (FIELD_W + 1)'(BOUND);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_REQ, S_WAIT, S_DONE} state_t;

    state_t                            state_q, state_d;
    logic [HASH_W-1:0]                 digest_q, digest_d;
    logic [HASH_W-1:0]                 shift_q, shift_d;
    logic [IW-1:0]                     idx_q, idx_d;
    logic [CW-1:0]                     chunk_cnt_q, chunk_cnt_d;
    logic [7:0]                        rehash_cnt_q, rehash_cnt_d;
    logic                              err_q, err_d;
    logic [NUM_OUT-1:0][FIELD_W-1:0]   out_vec_q, out_vec_d;
    logic [NUM_OUT-1:0][FIELD_W-1:0]   slot_nx;

    logic [FIELD_W-1:0] chunk;
    logic               accept, scan_acc, slot_clr, last_slot;

    assign chunk     = shift_q[HASH_W-1 -: FIELD_W];
    assign accept    = {1'b0, chunk} < BOUND_L;
    assign scan_acc  = (state_q == S_SCAN) && accept;
    assign slot_clr  = (state_q == S_IDLE) && start;
    assign last_slot = accept && (idx_q == IW'(NUM_OUT - 1));

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
        hcp_sampler_slot #(.FIELD_W(FIELD_W), .IW(IW), .IDX(g)) u_slot (
            .clk   (clk),
            .reset (reset),
            .clr   (slot_clr),
            .acc   (scan_acc),
            .idx   (idx_q),
            .chunk (chunk),
            .nxt   (slot_nx[g])
        );
    end

    always_comb begin
        state_d      = state_q;
        digest_d     = digest_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        chunk_cnt_d  = chunk_cnt_q;
        rehash_cnt_d = rehash_cnt_q;
        err_d        = err_q;
        out_vec_d    = out_vec_q;
        hash_req     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    digest_d     = seed;
                    shift_d      = seed;
                    idx_d        = '0;
                    chunk_cnt_d  = '0;
                    rehash_cnt_d = '0;
                    err_d        = 1'b0;
                    out_vec_d    = '0;
                    state_d      = S_SCAN;
                end
            end
            S_SCAN: begin
                shift_d     = shift_q << FIELD_W;
                chunk_cnt_d = chunk_cnt_q + CW'(1);
                if (accept)
                    idx_d = idx_q + IW'(1);
                // Filling the last slot wins over running out of chunks.
                if (last_slot) begin
                    for (int i = 0; i < NUM_OUT; i++)
                        out_vec_d[NUM_OUT-1-i] = slot_nx[i];
                    state_d = S_DONE;
                end else if (chunk_cnt_q == CW'(CHUNKS - 1)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // hash_valid is deliberately not looked at here: a result
                // coinciding with the request's first cycle is not accepted.
                if (rehash_cnt_q == 8'(MAX_REHASH)) begin
                    err_d     = 1'b1;
                    out_vec_d = '0;
                    state_d   = S_DONE;
                end else begin
                    hash_req = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                hash_req = 1'b1;
                if (hash_valid) begin
                    digest_d     = hash_out;
                    shift_d      = hash_out;
                    rehash_cnt_d = rehash_cnt_q + 8'd1;
                    chunk_cnt_d  = '0;
                    state_d      = S_SCAN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            digest_q     <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            chunk_cnt_q  <= '0;
            rehash_cnt_q <= '0;
            err_q        <= 1'b0;
            out_vec_q    <= '0;
        end else begin
            state_q      <= state_d;
            digest_q     <= digest_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            chunk_cnt_q  <= chunk_cnt_d;
            rehash_cnt_q <= rehash_cnt_d;
            err_q        <= err_d;
            out_vec_q    <= out_vec_d;
        end
    end

    assign hash_in    = hash_req ? digest_q : '0;
    assign busy       = (state_q == S_SCAN) || (state_q == S_REQ) || (state_q == S_WAIT);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign out_vec    = out_vec_q;
    assign rehash_cnt = rehash_cnt_q;
endmodule

// File: tb/tb_hcp_sampler_param.sv
module tb_hcp_sampler_param;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    // Instance A: default parameters, hash core driven by hand.
    logic         start_a, hv_a, hr_a, busy_a, done_a, err_a;
    logic [255:0] seed_a, ho_a, hi_a;
    logic [19:0]  ov_a;
    logic [7:0]   rc_a;
    hcp_sampler_param u_a (
        .clk(clk), .reset(reset), .start(start_a), .seed(seed_a),
        .hash_req(hr_a), .hash_in(hi_a), .hash_valid(hv_a), .hash_out(ho_a),
        .busy(busy_a), .done(done_a), .err(err_a), .out_vec(ov_a), .rehash_cnt(rc_a));

    // Instance B: MAX_REHASH=2, hash core always answers all-ones.
    logic         start_b, hv_b, hr_b, busy_b, done_b, err_b;
    logic [255:0] seed_b, ho_b, hi_b;
    logic [19:0]  ov_b;
    logic [7:0]   rc_b;
    hcp_sampler_param #(.MAX_REHASH(2)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .seed(seed_b),
        .hash_req(hr_b), .hash_in(hi_b), .hash_valid(hv_b), .hash_out(ho_b),
        .busy(busy_b), .done(done_b), .err(err_b), .out_vec(ov_b), .rehash_cnt(rc_b));

    // Instance D: parameter sweep FIELD_W=4, BOUND=10, NUM_OUT=8.
    logic         start_d, hv_d, hr_d, busy_d, done_d, err_d;
    logic [255:0] seed_d, ho_d, hi_d;
    logic [31:0]  ov_d;
    logic [7:0]   rc_d;
    hcp_sampler_param #(.FIELD_W(4), .BOUND(10), .NUM_OUT(8)) u_d (
        .clk(clk), .reset(reset), .start(start_d), .seed(seed_d),
        .hash_req(hr_d), .hash_in(hi_d), .hash_valid(hv_d), .hash_out(ho_d),
        .busy(busy_d), .done(done_d), .err(err_d), .out_vec(ov_d), .rehash_cnt(rc_d));

    typedef struct {
        logic [255:0] seed;
        logic [19:0]  exp_out;
        int           exp_lat;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] mk5(input int c0, input int c1, input int c2,
                                         input int c3, input int c4);
        logic [255:0] s;
        s = '0;
        s[255:251] = c0[4:0];
        s[250:246] = c1[4:0];
        s[245:241] = c2[4:0];
        s[240:236] = c3[4:0];
        s[235:231] = c4[4:0];
        return s;
    endfunction

    task automatic start_a_t(input logic [255:0] s);
        @(negedge clk);
        seed_a = s; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // cnt = number of edges after the start edge before done is seen.
    task automatic wait_done_a(input int lim, output int cnt);
        cnt = 0;
        while (done_a !== 1'b1 && cnt < lim) begin
            @(negedge clk);
            cnt++;
        end
        if (done_a !== 1'b1) begin
            nchk++; nerr++;
            $display("FAIL done_a_timeout: got no done expected done within %0d cycles", lim);
        end
    endtask

    task automatic wait_req_a(input int lim, output int cnt);
        cnt = 0;
        while (hr_a !== 1'b1 && cnt < lim) begin
            @(negedge clk);
            cnt++;
        end
        if (hr_a !== 1'b1) begin
            nchk++; nerr++;
            $display("FAIL req_a_timeout: got no hash_req expected one within %0d cycles", lim);
        end
    endtask

    // Hash core model for instance B: raises hash_valid every other cycle
    // while hash_req is high (so it also hits the REQ->WAIT edge), and counts
    // hash_req rising edges as handshakes.
    int   rises_b = 0;
    logic req_prev_b = 1'b0;
    initial begin
        hv_b = 1'b0;
        ho_b = '1;
        forever begin
            @(negedge clk);
            if (reset) hv_b = 1'b0;
            else       hv_b = hr_b && !hv_b;
            if (hr_b && !req_prev_b) rises_b++;
            req_prev_b = hr_b;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int cnt, last, got;
        logic [255:0] s;
        logic [31:0]  exp_d;
        logic [3:0]   nib;
        logic         ok;
        bit           seen;

        reset = 1'b1;
        start_a = 0; seed_a = '0; hv_a = 0; ho_a = '0;
        start_b = 0; seed_b = '0;
        start_d = 0; seed_d = '0; hv_d = 0; ho_d = '0;

        vecs[0] = '{mk5(3, 20, 7, 0, 15),   20'h19C0F, 6};
        vecs[1] = '{mk5(1, 2, 3, 4, 31),    20'h08864, 5};
        vecs[2] = '{mk5(16, 31, 16, 17, 5), 20'h28000, 9};
        vecs[3] = '{mk5(16, 16, 16, 16, 16), 20'h00000, 10};
        vecs[4] = '{mk5(15, 15, 15, 15, 15), 20'h7BDEF, 5};

        repeat (3) @(negedge clk);
        chk("rst_hash_req", 256'(hr_a), 256'(0));
        chk("rst_hash_in", hi_a, 256'(0));
        chk("rst_busy", 256'(busy_a), 256'(0));
        chk("rst_done", 256'(done_a), 256'(0));
        chk("rst_err", 256'(err_a), 256'(0));
        chk("rst_out_vec", 256'(ov_a), 256'(0));
        chk("rst_rehash_cnt", 256'(rc_a), 256'(0));
        reset = 1'b0;

        // Table-driven single-digest runs.
        for (int i = 0; i < 5; i++) begin
            start_a_t(vecs[i].seed);
            chk("vec_busy", 256'(busy_a), 256'(1));
            wait_done_a(100, cnt);
            chk("vec_latency", 256'(cnt + 1), 256'(vecs[i].exp_lat));
            chk("vec_out_vec", 256'(ov_a), 256'(vecs[i].exp_out));
            chk("vec_err", 256'(err_a), 256'(0));
            chk("vec_rehash_cnt", 256'(rc_a), 256'(0));
        end

        // start during DONE is ignored; out_vec holds.
        seed_a = vecs[0].seed; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("done_start_busy", 256'(busy_a), 256'(0));
        chk("done_start_done", 256'(done_a), 256'(0));
        chk("out_vec_hold", 256'(ov_a), 256'(20'h7BDEF));

        // All-ones seed: one re-hash. A start and a stray hash_valid during
        // the scan must both be ignored.
        ho_a = mk5(1, 2, 3, 4, 0);
        start_a_t('1);
        cnt = 0;
        while (hr_a !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (cnt == 10) seed_a = vecs[0].seed;
            start_a = (cnt == 10);
            hv_a    = (cnt == 20);
        end
        start_a = 1'b0; hv_a = 1'b0;
        chk("ones_req_latency", 256'(cnt), 256'(51));
        chk("ones_hash_in", hi_a, '1);
        repeat (2) @(negedge clk);
        chk("wait_req_held", 256'(hr_a), 256'(1));
        chk("wait_hash_in_held", hi_a, '1);
        @(negedge clk);
        hv_a = 1'b1;
        @(negedge clk);
        hv_a = 1'b0;
        chk("rehash_req_drop", 256'(hr_a), 256'(0));
        wait_done_a(100, cnt);
        chk("ones_out_vec", 256'(ov_a), 256'(20'h08864));
        chk("ones_rehash_cnt", 256'(rc_a), 256'(1));
        chk("ones_err", 256'(err_a), 256'(0));

        // Retry exhaustion on instance B.
        @(negedge clk);
        seed_b = '1; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cnt = 0;
        while (done_b !== 1'b1 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        chk("exh_done", 256'(done_b), 256'(1));
        chk("exh_err", 256'(err_b), 256'(1));
        chk("exh_out_vec", 256'(ov_b), 256'(0));
        chk("exh_rehash_cnt", 256'(rc_b), 256'(2));
        chk("exh_handshakes", 256'(rises_b), 256'(2));
        @(negedge clk);
        chk("exh_err_hold", 256'(err_b), 256'(1));

        // Slots 0-2 filled by chunks 48-50, slot 3 after the re-hash. hash_valid
        // is raised already in REQ and must only count from WAIT onward.
        s = '0;
        for (int j = 0; j < 51; j++)
            s = s | ((j < 48 ? 256'd31 : 256'(j - 43)) << (251 - 5 * j));
        start_a_t(s);
        wait_req_a(200, cnt);
        chk("bnd_req_latency", 256'(cnt), 256'(51));
        ho_a = 256'(9) << 251;
        hv_a = 1'b1;
        @(negedge clk);
        chk("req_edge_ignored_cnt", 256'(rc_a), 256'(0));
        chk("req_edge_ignored_req", 256'(hr_a), 256'(1));
        @(negedge clk);
        hv_a = 1'b0;
        chk("bnd_rehash_cnt_step", 256'(rc_a), 256'(1));
        wait_done_a(100, cnt);
        chk("bnd_out_vec", 256'(ov_a), 256'(20'h298E9));

        // Last slot filled by the final chunk of the digest: DONE, not REQ.
        s = '1;
        s[20:1] = 20'h08864;
        start_a_t(s);
        wait_done_a(100, cnt);
        chk("last_chunk_latency", 256'(cnt + 1), 256'(52));
        chk("last_chunk_out_vec", 256'(ov_a), 256'(20'h08864));
        chk("last_chunk_rehash", 256'(rc_a), 256'(0));

        // Reset while waiting for the hash core; the late result is dropped.
        start_a_t('1);
        wait_req_a(200, cnt);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ho_a = mk5(1, 2, 3, 4, 0);
        hv_a = 1'b1;
        @(negedge clk);
        hv_a = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (done_a || hr_a || busy_a) seen = 1'b1;
            @(negedge clk);
        end
        chk("rst_wait_activity", 256'(seen), 256'(0));
        chk("rst_wait_rehash_cnt", 256'(rc_a), 256'(0));
        chk("rst_wait_out_vec", 256'(ov_a), 256'(0));
        start_a_t(vecs[1].seed);
        wait_done_a(100, cnt);
        chk("after_rst_latency", 256'(cnt + 1), 256'(5));
        chk("after_rst_out_vec", 256'(ov_a), 256'(20'h08864));

        // Parameter sweep against a software model.
        for (int k = 0; k < 3; k++) begin
            do begin
                for (int w = 0; w < 8; w++) s[w*32 +: 32] = $urandom();
                if (k == 0) s[255:232] = 24'hABCDEF;
                exp_d = '0; got = 0; last = 0;
                for (int j = 0; j < 64; j++) begin
                    nib = s[255 - 4*j -: 4];
                    if (nib < 4'd10 && got < 8) begin
                        exp_d = (exp_d << 4) | 32'(nib);
                        got++;
                        last = j;
                    end
                end
            end while (got < 8);
            @(negedge clk);
            seed_d = s; start_d = 1'b1;
            @(negedge clk);
            start_d = 1'b0;
            cnt = 0;
            while (done_d !== 1'b1 && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            chk("sweep_latency", 256'(cnt + 1), 256'(last + 2));
            chk("sweep_out_vec", 256'(ov_d), 256'(exp_d));
            ok = 1'b1;
            for (int q = 0; q < 8; q++)
                if (ov_d[q*4 +: 4] >= 4'd10) ok = 1'b0;
            chk("sweep_skip_10_15", 256'(ok), 256'(1));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
